axi_sram_rd_engine: RTL and testbench

Parametrised AXI4 read-channel slave that turns AR bursts into SRAM word reads and returns R beats with full RREADY back-pressure. It supports FIXED, INCR and WRAP bursts, echoes ARID and checks ARSIZE/ARLEN legality. It tolerates a configurable SRAM read latency through a credit-controlled return FIFO. It sits between the AXI interconnect and the SRAM macro, alongside the write-channel block.

---
 rtl/axi_sram_rd_engine.sv | 185 ++++++++++++++++++
 tb/tb_axi_sram_rd_engine.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_rd_engine.sv
// AXI4 read-channel slave. It turns AR bursts into SRAM word reads and returns
// R beats through a credit-controlled FIFO that absorbs the SRAM read latency.
module axi_sram_rd_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int SRAM_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                        ACLK,
  input  logic                                        ARESET,
  input  logic [ID_WIDTH-1:0]                         ARID,
  input  logic [ADDR_WIDTH-1:0]                       ARADDR,
  input  logic [7:0]                                  ARLEN,
  input  logic [2:0]                                  ARSIZE,
  input  logic [1:0]                                  ARBURST,
  input  logic                                        ARVALID,
  output logic                                        ARREADY,
  output logic [ID_WIDTH-1:0]                         RID,
  output logic [DATA_WIDTH-1:0]                       RDATA,
  output logic [1:0]                                  RRESP,
  output logic                                        RLAST,
  output logic                                        RVALID,
  input  logic                                        RREADY,
  output logic                                        sram_ren,
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  sram_addr,
  input  logic [DATA_WIDTH-1:0]                       sram_rdata,
  output logic                                        dbg_state
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; once RVALID rises, RID/RDATA/RRESP/RLAST hold until that edge.
  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_WIDTH + 3;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  state_t state, state_nx;

  logic                  init_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx, step, wrap_mask;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q, ar_err, ar_hs;
  logic [8:0]            issued_q;
  logic                  beats_left, last_beat, err_push, issue;
  logic [SRAM_LAT-1:0]   vpipe, lpipe;
  logic [PW:0]           in_flight, count;
  logic [PW+1:0]         credit;
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;
  logic [EW-1:0]         push_entry, head;

  assign ar_hs = ARVALID & ARREADY;

  always_comb begin
    ar_err = 1'b0;
    if (ARSIZE > 3'(LSB)) ar_err = 1'b1;
    if (ARBURST == 2'b11) ar_err = 1'b1;
    if (ARBURST == 2'b10) begin
      if (!(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_err = 1'b1;
      if ((ARADDR & ((ADDR_WIDTH'(1) << ARSIZE) - ADDR_WIDTH'(1))) != '0) ar_err = 1'b1;
    end
  end

  // INCR aligns down before stepping, so only the first beat can be unaligned.
  assign step      = ADDR_WIDTH'(1) << size_q;
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
  always_comb begin
    addr_nx = addr_q;
    case (burst_q)
      2'b01:   addr_nx = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
      2'b10:   addr_nx = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: addr_nx = addr_q;
    endcase
  end

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < SRAM_LAT; i++) in_flight = in_flight + (PW+1)'(vpipe[i]);
  end

  assign credit     = (PW+2)'(in_flight) + (PW+2)'(count);
  assign beats_left = (issued_q <= {1'b0, len_q});
  assign last_beat  = (issued_q == {1'b0, len_q});
  assign err_push   = (state == BURST) & err_q & beats_left & (count < (PW+1)'(FIFO_DEPTH));
  assign issue      = sram_ren | err_push;

  // FSM: state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ar_hs) state_nx = BURST;
      BURST:   if (pop && head[DATA_WIDTH]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ARREADY  = (state == IDLE) & init_q;
    sram_ren = (state == BURST) & ~err_q & beats_left & (credit < (PW+2)'(FIFO_DEPTH));
  end

  assign dbg_state = state;
  assign sram_addr = addr_q[ADDR_WIDTH-1:LSB];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q   <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      issued_q <= '0;
    end else begin
      init_q <= 1'b1;
      if (ar_hs) begin
        id_q     <= ARID;
        addr_q   <= ARADDR;
        len_q    <= ARLEN;
        size_q   <= ARSIZE;
        burst_q  <= ARBURST;
        err_q    <= ar_err;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + 9'd1;
        if (sram_ren) addr_q <= addr_nx;
      end
    end
  end

  // Each read is tagged so its data is captured exactly SRAM_LAT cycles later.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe[0] <= sram_ren;
      lpipe[0] <= sram_ren & last_beat;
      for (int i = 1; i < SRAM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        lpipe[i] <= lpipe[i-1];
      end
    end
  end

  assign push       = err_push | vpipe[SRAM_LAT-1];
  assign push_entry = err_push ? {2'b10, last_beat, DATA_WIDTH'(0)}
                               : {2'b00, lpipe[SRAM_LAT-1], sram_rdata};
  assign head       = mem[rd_ptr];
  assign RVALID     = (count != '0);
  assign pop        = RVALID & RREADY;

  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign RID   = id_q;
  assign RDATA = RVALID ? head[DATA_WIDTH-1:0] : '0;
  assign RLAST = RVALID & head[DATA_WIDTH];
  assign RRESP = RVALID ? head[EW-1:EW-2] : 2'b00;
endmodule

// File: tb/tb_axi_sram_rd_engine.sv
// Directed bench for axi_sram_rd_engine (SRAM_LAT=2) with a burst-level model,
// an SRAM behavioural model and a per-cycle scoreboard on the AR/R/SRAM ports.
module tb_axi_sram_rd_engine;
  localparam int DW = 32, AW = 16, IW = 4, LAT = 2, DEPTH = 4, LSB = 2;
  localparam int WW = AW - LSB;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [IW-1:0] ARID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic          ARVALID, ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST, RVALID, RREADY;
  logic          sram_ren;
  logic [WW-1:0] sram_addr;
  logic [DW-1:0] sram_rdata;
  logic          dbg_state;

  axi_sram_rd_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                       .SRAM_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .sram_ren(sram_ren), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- SRAM model ----------------
  function automatic logic [DW-1:0] mem_word(input logic [WW-1:0] w);
    return {2'b10, w, 2'b01, ~w};
  endfunction

  logic [DW-1:0] sp [LAT];
  initial foreach (sp[i]) sp[i] = '0;
  always @(posedge ACLK) begin
    sp[0] <= sram_ren ? mem_word(sram_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
  end
  assign sram_rdata = sp[LAT-1];

  // ---------------- burst model ----------------
  function automatic logic [AW-1:0] beat_addr(input int start, input int len,
                                              input int size, input int bt, input int i);
    int step, wb, low;
    step = 1 << size;
    wb   = (len + 1) * step;
    case (bt)
      0:       return AW'(start);
      1:       return (i == 0) ? AW'(start) : AW'((start / step) * step + i * step);
      default: begin
        low = (start / wb) * wb;
        return AW'(low + ((start - low + i * step) % wb));
      end
    endcase
  endfunction

  function automatic bit model_err(input int start, input int len, input int size, input int bt);
    bit e;
    e = (size > LSB) || (bt == 3);
    if (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1;
    if (bt == 2 && (start % (1 << size)) != 0) e = 1;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  logic [IW+2+1+DW-1:0] exp_q[$];
  logic [WW-1:0]        exp_addr_q[$];
  logic [WW-1:0]        seen_addr_q[$];
  int                   lit_q[$];
  int  first_ren = -1, first_rv = -1, last_hs = -1;
  int  ren_total = 0, pop_total = 0;
  bit  pending = 0;
  bit  rr_rand = 0;

  always @(negedge ACLK) begin
    if (ARESET) begin
      pending = 0;
    end else begin
      if (sram_ren) begin
        if (first_ren < 0) first_ren = cyc;
        seen_addr_q.push_back(sram_addr);
        chk("credit", 64'(ren_total + 1 - pop_total <= DEPTH), 64'd1);
        if (exp_addr_q.size() == 0) fail_now("ren_unexpected", 64'(sram_addr));
        else chk("sram_addr", 64'(sram_addr), 64'(exp_addr_q.pop_front()));
        ren_total++;
      end
      if (RVALID) begin
        if (first_rv < 0) first_rv = cyc;
        if (exp_q.size() == 0) fail_now("r_unexpected", 64'({RID, RRESP, RLAST, RDATA}));
        else chk("r_beat", 64'({RID, RRESP, RLAST, RDATA}), 64'(exp_q[0]));
        if (RREADY) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pop_total++;
          if (RLAST) last_hs = cyc;
        end
        pending = !RREADY;
      end else if (pending) begin
        chk("rvalid_held", 64'(RVALID), 64'd1);
        pending = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial forever begin
    @(posedge ACLK);
    #1;
    RREADY = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int t_ar = 0, cur_n = 0;
  bit cur_err = 0;

  task automatic load_exp(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] bt);
    logic [AW-1:0] a;
    logic [1:0]    resp;
    logic [DW-1:0] d;
    logic          lb;
    cur_err = model_err(int'(addr), int'(len), int'(size), int'(bt));
    cur_n   = int'(len) + 1;
    for (int i = 0; i < cur_n; i++) begin
      a    = beat_addr(int'(addr), int'(len), int'(size), int'(bt), i);
      resp = cur_err ? 2'b10 : 2'b00;
      d    = cur_err ? '0 : mem_word(a[AW-1:LSB]);
      lb   = (i == cur_n - 1);
      if (!cur_err) exp_addr_q.push_back(a[AW-1:LSB]);
      exp_q.push_back({id, resp, lb, d});
    end
    first_ren = -1; first_rv = -1; last_hs = -1;
    ren_total = 0;  pop_total = 0;
    seen_addr_q.delete();
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] bt);
    int k;
    @(posedge ACLK);
    #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = bt; ARVALID = 1'b1;
    k = 0;
    do begin
      @(negedge ACLK);
      k++;
    end while (!ARREADY && k < 50);
    if (!ARREADY) fail_now("arready_timeout", 64'(k));
    @(posedge ACLK);
    #1;
    t_ar = cyc;
    ARVALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rr);
    int k;
    k = 0;
    while (last_hs < 0 && k < 400) begin
      @(posedge ACLK);
      k++;
    end
    if (last_hs < 0) fail_now({tag, "_timeout"}, 64'(k));
    @(negedge ACLK);
    chk({tag, "_arready_after"}, 64'(ARREADY), 64'd1);
    chk({tag, "_drained"}, 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
    if (cur_err) begin
      chk({tag, "_err_first_rvalid"}, 64'(first_rv), 64'(t_ar + 1));
      chk({tag, "_err_no_ren"}, 64'(ren_total), 64'd0);
      if (!rr) chk({tag, "_err_last"}, 64'(last_hs), 64'(t_ar + cur_n));
    end else if (!rr) begin
      chk({tag, "_first_ren"}, 64'(first_ren), 64'(t_ar));
      chk({tag, "_first_rvalid"}, 64'(first_rv), 64'(t_ar + 1 + LAT));
      chk({tag, "_last"}, 64'(last_hs), 64'(t_ar + cur_n + LAT));
    end
  endtask

  task automatic run_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] bt,
                           input bit rr);
    #1;
    load_exp(id, addr, len, size, bt);
    rr_rand = rr;
    send_ar(id, addr, len, size, bt);
    wait_done(tag, rr);
    rr_rand = 0;
  endtask

  task automatic chk_seen(input string tag);
    chk({tag, "_nreads"}, 64'(seen_addr_q.size()), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < seen_addr_q.size(); i++)
      chk({tag, "_read_addr"}, 64'(seen_addr_q[i]), 64'(lit_q[i]));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_arready"}, 64'(ARREADY), 64'd0);
    chk({tag, "_rvalid"}, 64'(RVALID), 64'd0);
    chk({tag, "_rlast"}, 64'(RLAST), 64'd0);
    chk({tag, "_rresp"}, 64'(RRESP), 64'd0);
    chk({tag, "_rid"}, 64'(RID), 64'd0);
    chk({tag, "_rdata"}, 64'(RDATA), 64'd0);
    chk({tag, "_ren"}, 64'(sram_ren), 64'd0);
    chk({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    ARESET = 1'b1; ARVALID = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0;
    ARSIZE = '0; ARBURST = '0; RREADY = 1'b1;

    // hand-computed pins on the model itself
    chk("model_wrap_b1", 64'(beat_addr(16'h38, 3, 2, 2, 1)), 64'h3C);
    chk("model_wrap_b2", 64'(beat_addr(16'h38, 3, 2, 2, 2)), 64'h30);
    chk("model_incr_unaligned_b1", 64'(beat_addr(16'h13, 2, 2, 1, 1)), 64'h14);
    chk("model_err_size", 64'(model_err(0, 2, 3, 1)), 64'd1);

    repeat (3) @(posedge ACLK);
    #1;
    chk_reset_outs("reset");
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("arready_before_edge", 64'(ARREADY), 64'd0);
    @(negedge ACLK);
    chk("arready_after_reset", 64'(ARREADY), 64'd1);

    run_burst("incr4", 4'h5, 16'h0010, 8'd3, 3'd2, 2'b01, 0);
    lit_q = '{4, 5, 6, 7};
    chk_seen("incr4");

    run_burst("wrap4", 4'h6, 16'h0038, 8'd3, 3'd2, 2'b10, 0);
    lit_q = '{'hE, 'hF, 'hC, 'hD};
    chk_seen("wrap4");

    run_burst("fixed8", 4'h7, 16'h0100, 8'd7, 3'd2, 2'b00, 0);
    lit_q = '{'h40, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};
    chk_seen("fixed8");

    run_burst("incr16_bp", 4'h8, 16'h0200, 8'd15, 3'd2, 2'b01, 1);
    run_burst("err_size", 4'h9, 16'h0000, 8'd2, 3'd3, 2'b01, 0);
    run_burst("incr_unaligned", 4'h1, 16'h0013, 8'd2, 3'd2, 2'b01, 0);
    run_burst("incr_narrow", 4'h2, 16'h0021, 8'd3, 3'd0, 2'b01, 0);
    lit_q = '{8, 8, 8, 9};
    chk_seen("incr_narrow");
    run_burst("err_wrap_len", 4'h3, 16'h0040, 8'd2, 3'd2, 2'b10, 0);
    run_burst("err_wrap_align", 4'h4, 16'h0042, 8'd3, 3'd2, 2'b10, 0);
    run_burst("err_burst11", 4'hA, 16'h0000, 8'd0, 3'd2, 2'b11, 0);
    run_burst("incr_addr_wrap", 4'hB, 16'hFFFC, 8'd1, 3'd2, 2'b01, 0);
    lit_q = '{'h3FFF, 0};
    chk_seen("incr_addr_wrap");
    run_burst("wrap8", 4'hC, 16'h0054, 8'd7, 3'd2, 2'b10, 1);

    // reset in the middle of a burst
    #1;
    load_exp(4'hD, 16'h0400, 8'd7, 3'd2, 2'b01);
    send_ar(4'hD, 16'h0400, 8'd7, 3'd2, 2'b01);
    k = 0;
    while (pop_total < 2 && k < 100) begin
      @(posedge ACLK);
      k++;
    end
    if (pop_total < 2) fail_now("midreset_wait_timeout", 64'(k));
    #2;
    ARESET = 1'b1;
    #1;
    chk_reset_outs("midreset");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("midreset_arready", 64'(ARREADY), 64'd1);
    chk("midreset_idle_rvalid", 64'(RVALID), 64'd0);
    run_burst("after_reset", 4'h3, 16'h0020, 8'd1, 3'd2, 2'b01, 0);
    lit_q = '{8, 9};
    chk_seen("after_reset");

    repeat (5) @(posedge ACLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
